taxi_fare_ctrl: RTL

//  Trip controller for the taxi meter. Sequences a fare through idle/run/wait/hold,

---
 rtl/taxi_fare_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/taxi_fare_ctrl.sv
// Taxi meter trip controller: IDLE/RUN/WAIT/HOLD sequencing with saturating fare and distance accumulators.
// Optional night tariff on the per-km charge is enabled by defining NIGHT_RATE_EN.
module taxi_fare_ctrl #(
  parameter int BASE_FARE = 1000,
  parameter int BASE_DIST = 300,
  parameter int KM_FARE   = 200,
  parameter int WAIT_FARE = 100,
  parameter int TICK_DIV  = 20000000,
  parameter int WAIT_SECS = 60
) (
  input  logic        clk20mhz,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic        clear,
  input  logic        wheel_pulse,
`ifdef NIGHT_RATE_EN
  input  logic        night,
`endif
  output logic [12:0] money_out,
  output logic [12:0] distance_out,
  output logic [1:0]  state_out,
  output logic        sat
);

  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PERIOD_W = ($clog2(WAIT_SECS) > 6) ? $clog2(WAIT_SECS) : 6;

  localparam logic [12:0]         BASE_FARE_L   = 13'(BASE_FARE);
  localparam logic [12:0]         BASE_DIST_L   = 13'(BASE_DIST);
  localparam logic [12:0]         KM_FARE_DAY   = 13'(KM_FARE);
  localparam logic [12:0]         KM_FARE_NIGHT = 13'(KM_FARE + KM_FARE / 2);
  localparam logic [12:0]         WAIT_FARE_L   = 13'(WAIT_FARE);
  localparam logic [6:0]          KM_LAST       = 7'd99;
  localparam logic [PRESC_W-1:0]  TICK_LAST     = PRESC_W'(TICK_DIV - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST   = PERIOD_W'(WAIT_SECS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WAIT = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_wp_s1;
  logic                r_wp_s2;
  logic                r_wp_s3;
  logic                w_wheel_edge;
  logic                w_new_trip;
  logic [12:0]         w_km_charge;
  logic [12:0]         r_money;
  logic [12:0]         r_dist;
  logic [6:0]          r_km;
  logic [PRESC_W-1:0]  r_presc;
  logic [PERIOD_W-1:0] r_period;
  logic                r_sat;
  logic [12:0]         w_money_next;
  logic [12:0]         w_dist_next;
  logic [6:0]          w_km_next;
  logic [PRESC_W-1:0]  w_presc_next;
  logic [PERIOD_W-1:0] w_period_next;
  logic                w_sat_next;
  logic [13:0]         w_money_sum;
  logic [13:0]         w_dist_sum;

  // Returns {overflow, value}; value clamps at 8191 on overflow.
  function automatic logic [13:0] f_sat_add(input logic [12:0] a, input logic [12:0] b);
    logic [13:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[13]) begin
      f_sat_add = {1'b1, 13'h1FFF};
    end else begin
      f_sat_add = s;
    end
  endfunction

  // Wheel sensor is asynchronous: two sync flops, third flop for edge detect.
  always_ff @(posedge clk20mhz) begin
    if (!rst_n) begin
      r_wp_s1 <= 1'b0;
      r_wp_s2 <= 1'b0;
      r_wp_s3 <= 1'b0;
    end else begin
      r_wp_s1 <= wheel_pulse;
      r_wp_s2 <= r_wp_s1;
      r_wp_s3 <= r_wp_s2;
    end
  end

  assign w_wheel_edge = r_wp_s2 & ~r_wp_s3;

`ifdef NIGHT_RATE_EN
  assign w_km_charge = night ? KM_FARE_NIGHT : KM_FARE_DAY;
`else
  assign w_km_charge = KM_FARE_DAY;
  localparam logic [12:0] UNUSED_NIGHT = KM_FARE_NIGHT;
`endif

  always_ff @(posedge clk20mhz) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_IDLE;
    end else if (stop) begin
      if (r_state == S_RUN || r_state == S_WAIT) begin
        w_state_next = S_HOLD;
      end
    end else if (start && (r_state == S_IDLE || r_state == S_HOLD)) begin
      w_state_next = S_RUN;
    end else if (r_state == S_RUN && pause) begin
      w_state_next = S_WAIT;
    end else if (r_state == S_WAIT && !pause) begin
      w_state_next = S_RUN;
    end
  end

  // Stop cycle freezes the datapath; a simultaneous start never opens a trip.
  always_comb begin
    w_new_trip    = !clear && !stop && start && (r_state == S_IDLE || r_state == S_HOLD);
    w_money_next  = r_money;
    w_dist_next   = r_dist;
    w_km_next     = r_km;
    w_presc_next  = r_presc;
    w_period_next = r_period;
    w_sat_next    = r_sat;
    w_money_sum   = '0;
    w_dist_sum    = '0;
    if (clear) begin
      w_money_next  = '0;
      w_dist_next   = '0;
      w_km_next     = '0;
      w_presc_next  = '0;
      w_period_next = '0;
      w_sat_next    = 1'b0;
    end else if (w_new_trip) begin
      w_money_next  = BASE_FARE_L;
      w_dist_next   = '0;
      w_km_next     = '0;
      w_presc_next  = '0;
      w_period_next = '0;
      w_sat_next    = 1'b0;
    end else if (!stop) begin
      if (r_state == S_RUN && w_wheel_edge) begin
        w_dist_sum  = f_sat_add(r_dist, 13'd1);
        w_dist_next = w_dist_sum[12:0];
        if (w_dist_sum[13]) begin
          w_sat_next = 1'b1;
        end
        if (r_dist >= BASE_DIST_L) begin
          if (r_km == KM_LAST) begin
            w_km_next    = '0;
            w_money_sum  = f_sat_add(r_money, w_km_charge);
            w_money_next = w_money_sum[12:0];
            if (w_money_sum[13]) begin
              w_sat_next = 1'b1;
            end
          end else begin
            w_km_next = r_km + 7'd1;
          end
        end
      end else if (r_state == S_WAIT) begin
        if (r_presc == TICK_LAST) begin
          w_presc_next = '0;
          if (r_period == PERIOD_LAST) begin
            w_period_next = '0;
            w_money_sum   = f_sat_add(r_money, WAIT_FARE_L);
            w_money_next  = w_money_sum[12:0];
            if (w_money_sum[13]) begin
              w_sat_next = 1'b1;
            end
          end else begin
            w_period_next = r_period + 1'b1;
          end
        end else begin
          w_presc_next = r_presc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk20mhz) begin
    if (!rst_n) begin
      r_money  <= '0;
      r_dist   <= '0;
      r_km     <= '0;
      r_presc  <= '0;
      r_period <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_money  <= w_money_next;
      r_dist   <= w_dist_next;
      r_km     <= w_km_next;
      r_presc  <= w_presc_next;
      r_period <= w_period_next;
      r_sat    <= w_sat_next;
    end
  end

  assign money_out    = r_money;
  assign distance_out = r_dist;
  assign state_out    = r_state;
  assign sat          = r_sat;

endmodule
